// File: rtl/mmv_swu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmv_swu_pkg
// Description : Shared sizing helpers for the MMV sliding-window unit and its
//               input packer (frame beat/word counts, counter widths).
// Revision    : 1.0 - initial release
// ============================================================================
package mmv_swu_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // $clog2(1) is 0; a counter still needs one bit to exist.
  function automatic int safe_clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int frame_beats(input int height, input int width,
                                     input int channels, input int simd);
    return height * width * channels / simd;
  endfunction

  function automatic int frame_words(input int beats, input int mmv);
    return ceil_div(beats, mmv);
  endfunction

  function automatic int frame_remainder(input int beats, input int mmv);
    return beats % mmv;
  endfunction

  function automatic int lane_width(input int mmv);
    return safe_clog2(mmv);
  endfunction

  function automatic int beat_width(input int beats);
    return safe_clog2(beats);
  endfunction

  function automatic int word_width(input int simd, input int precision, input int mmv);
    return simd * precision * mmv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmv_input_packer.sv
`default_nettype none
// ============================================================================
// Module      : mmv_input_packer
// Description : Packs MMV consecutive SIMD-wide beats into one output word,
//               zero-padding the final word of a frame and flagging it last.
// Revision    : 1.0 - initial release
// ============================================================================
module mmv_input_packer
  import mmv_swu_pkg::*;
#(
  parameter int SIMD         = 1,
  parameter int IP_PRECISION = 8,
  parameter int MMV          = 2,
  parameter int IFMChannels  = 2,
  parameter int IFMWidth     = 8,
  parameter int IFMHeight    = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [SIMD*IP_PRECISION-1:0]        ip_axis_tdata,
  input  logic                                ip_axis_tvalid,
  output logic                                ip_axis_tready,
  output logic [MMV*SIMD*IP_PRECISION-1:0]    op_axis_tdata,
  output logic                                op_axis_tvalid,
  input  logic                                op_axis_tready,
  output logic                                op_axis_tlast
);

  localparam int c_n_beats = frame_beats(IFMHeight, IFMWidth, IFMChannels, SIMD);
  localparam int c_beat_w  = beat_width(c_n_beats);
  localparam int c_lane_w  = lane_width(MMV);
  localparam int c_beat_lb = SIMD * IP_PRECISION;
  localparam int c_word_w  = word_width(SIMD, IP_PRECISION, MMV);

  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_n_beats - 1);
  localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(MMV - 1);

  logic [c_lane_w-1:0] r_lane;
  logic [c_beat_w-1:0] r_beat;
  logic [c_word_w-1:0] r_acc;
  logic [c_word_w-1:0] r_out;
  logic                r_valid;
  logic                r_last;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_frame_end;
  logic                w_closing;
  logic [c_word_w-1:0] w_merged;

  assign ip_axis_tready = ~reset & (~r_valid | op_axis_tready);
  assign w_in_fire      = ip_axis_tvalid & ip_axis_tready;
  assign w_out_fire     = r_valid & op_axis_tready;
  assign w_frame_end    = (r_beat == c_last_beat);
  assign w_closing      = w_in_fire & ((r_lane == c_last_lane) | w_frame_end);

  // Lanes above the current one are still zero in r_acc, which gives the
  // padding of a short final word for free.
  for (genvar k = 0; k < MMV; k++) begin : g_lane
    assign w_merged[k*c_beat_lb +: c_beat_lb] =
      (r_lane == c_lane_w'(k)) ? ip_axis_tdata : r_acc[k*c_beat_lb +: c_beat_lb];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane  <= '0;
      r_beat  <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_beat <= w_frame_end ? '0 : r_beat + 1'b1;
        if (w_closing) begin
          r_lane <= '0;
          r_acc  <= '0;
        end else begin
          r_lane <= r_lane + 1'b1;
          r_acc  <= w_merged;
        end
      end

      if (w_closing) begin
        r_out   <= w_merged;
        r_valid <= 1'b1;
        r_last  <= w_frame_end;
      end else if (w_out_fire) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign op_axis_tdata  = r_out;
  assign op_axis_tvalid = r_valid;
  assign op_axis_tlast  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_mmv_input_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmv_input_packer
// Description : Self-checking bench: four packer configurations, each watched
//               every cycle by a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmv_input_packer;

  // cfg0: MMV=2 3x3x1, cfg1: MMV=1 2x2x1, cfg2: MMV=3 N=10, cfg3: defaults
  localparam int CFG_MMV [4] = '{2, 1, 3, 2};
  localparam int CFG_H   [4] = '{3, 2, 2, 8};
  localparam int CFG_W   [4] = '{3, 2, 5, 8};
  localparam int CFG_C   [4] = '{1, 1, 1, 2};

  logic        clk;
  logic        rst       [4];
  logic [7:0]  in_data   [4];
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [23:0] out_data  [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic        out_last  [4];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int M = CFG_MMV[g];
    localparam int N = CFG_H[g] * CFG_W[g] * CFG_C[g];

    logic [M*8-1:0] od;
    logic [24:0]    got [$];
    logic [24:0]    expq [$];
    logic [23:0]    acc = '0;
    int             beat = 0;

    mmv_input_packer #(
      .SIMD(1), .IP_PRECISION(8), .MMV(M),
      .IFMChannels(CFG_C[g]), .IFMWidth(CFG_W[g]), .IFMHeight(CFG_H[g])
    ) u_dut (
      .clk           (clk),
      .reset         (rst[g]),
      .ip_axis_tdata (in_data[g]),
      .ip_axis_tvalid(in_valid[g]),
      .ip_axis_tready(in_ready[g]),
      .op_axis_tdata (od),
      .op_axis_tvalid(out_valid[g]),
      .op_axis_tready(out_ready[g]),
      .op_axis_tlast (out_last[g])
    );
    assign out_data[g] = 24'(od);

    // Reference: beat b of a frame lands in lane (b mod M); a word is complete
    // when its top lane is filled or the frame ends.
    always @(negedge clk) begin
      int lane;
      chk("tready", 32'(in_ready[g]), 32'(!rst[g] && (!out_valid[g] || out_ready[g])));
      chk("tvalid", 32'(out_valid[g]), 32'(expq.size() != 0));
      if (out_valid[g] && expq.size() != 0)
        chk("word", 32'({out_last[g], out_data[g]}), 32'(expq[0]));
      if (rst[g]) begin
        expq.delete();
        acc  = '0;
        beat = 0;
      end else begin
        if (out_valid[g] && out_ready[g]) begin
          got.push_back({out_last[g], out_data[g]});
          if (expq.size() != 0) void'(expq.pop_front());
        end
        if (in_valid[g] && in_ready[g]) begin
          lane = beat % M;
          acc[lane*8 +: 8] = in_data[g];
          if (lane == M - 1 || beat == N - 1) begin
            expq.push_back({beat == N - 1, acc});
            acc = '0;
          end
          beat = (beat + 1) % N;
        end
      end
    end
  end

  // Offers nb beats on instance i. Data is base+k unless rnd; rnd also toggles
  // tvalid/tready. stall>0 holds tready low until the first word has been
  // stalled for that many cycles.
  task automatic stream(input int i, input int nb, input int base, input bit rnd, input int stall);
    int sent = 0;
    int cyc  = 0;
    int st   = -1;
    if (stall > 0) out_ready[i] = 1'b0;
    while (sent < nb) begin
      @(posedge clk); #1;
      in_valid[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data[i]  = rnd ? 8'($urandom) : 8'(base + sent);
      if (rnd) out_ready[i] = ($urandom_range(0, 3) != 0);
      else if (st == 0) out_ready[i] = 1'b1;
      @(negedge clk);
      if (stall > 0) begin
        if (st < 0 && out_valid[i]) st = stall;
        if (st > 0) begin
          chk("stall_hold", 32'(out_data[i]), 32'h0201);
          chk("stall_tready", 32'(in_ready[i]), 32'h0);
          st--;
        end
      end
      if (in_valid[i] && in_ready[i]) sent++;
      cyc++;
      if (cyc > 40000) begin
        chk("stream_timeout", 32'(sent), 32'(nb));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    @(posedge clk); #1;
    out_ready[i] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [24:0] exp1 [5];
    int base;
    int lasts;
    exp1 = '{25'h0000201, 25'h0000403, 25'h0000605, 25'h0000807, 25'h1000009};
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid[0]), 32'h0);
    chk("rst_last", 32'(out_last[0]), 32'h0);
    chk("rst_data", 32'(out_data[0]), 32'h0);
    chk("rst_tready", 32'(in_ready[0]), 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 32'(in_ready[0]), 32'h1);

    // 3x3 frame, 0x01..0x09, sink always ready
    base = g_cfg[0].got.size();
    stream(0, 9, 1, 1'b0, 0);
    drain(0);
    chk("f1_count", 32'(g_cfg[0].got.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) chk("f1_word", 32'(g_cfg[0].got[base+k]), 32'(exp1[k]));

    // same frame, sink stalled 5 cycles after first word
    base = g_cfg[0].got.size();
    stream(0, 9, 1, 1'b0, 5);
    drain(0);
    chk("stall_count", 32'(g_cfg[0].got.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) chk("stall_word", 32'(g_cfg[0].got[base+k]), 32'(exp1[k]));

    // reset with a word pending at the output
    out_ready[0] = 1'b0;
    stream(0, 2, 1, 1'b0, 0);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid[0]), 32'h0);
    out_ready[0] = 1'b1;
    base = g_cfg[0].got.size();
    stream(0, 2, 8'hA0, 1'b0, 0);
    stream(0, 7, 1, 1'b0, 0);
    drain(0);
    chk("mid_rst_count", 32'(g_cfg[0].got.size() - base), 32'd5);
    chk("mid_rst_first", 32'(g_cfg[0].got[base]), 32'h000A1A0);
    chk("mid_rst_tlast", 32'(g_cfg[0].got[base+4][24]), 32'h1);

    // MMV=1 pass-through
    base = g_cfg[1].got.size();
    stream(1, 4, 1, 1'b0, 0);
    drain(1);
    chk("mmv1_count", 32'(g_cfg[1].got.size() - base), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("mmv1_word", 32'(g_cfg[1].got[base+k]), 32'((k == 3 ? 32'h1000000 : 32'h0) + k + 1));

    // two back-to-back default frames
    base = g_cfg[3].got.size();
    stream(3, 256, 0, 1'b0, 0);
    drain(3);
    chk("dflt_count", 32'(g_cfg[3].got.size() - base), 32'd128);
    lasts = 0;
    for (int k = 0; k < 128; k++) lasts += int'(g_cfg[3].got[base+k][24]);
    chk("dflt_nlast", 32'(lasts), 32'd2);
    chk("dflt_last1", 32'(g_cfg[3].got[base+63][24]), 32'h1);
    chk("dflt_last2", 32'(g_cfg[3].got[base+127][24]), 32'h1);
    chk("dflt_f2_first", 32'(g_cfg[3].got[base+64]), 32'h0008180);

    // 1000 frames of N=10, MMV=3, random handshakes
    base = g_cfg[2].got.size();
    stream(2, 10000, 0, 1'b1, 0);
    drain(2);
    chk("rnd_count", 32'(g_cfg[2].got.size() - base), 32'd4000);
    for (int k = 0; k < 4000; k++) begin
      chk("rnd_tlast", 32'(g_cfg[2].got[base+k][24]), 32'(k % 4 == 3));
      if (k % 4 == 3) chk("rnd_pad", 32'(g_cfg[2].got[base+k][23:8]), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
